pwm_mch: RTL and testbench

- Multi-channel PWM generator; the next generation of the single-channel PWM block.
- N channels share one timebase counter. Each channel has its own duty compare, enable and invert.
- Adds centre-aligned mode and glitch-free shadow-register updates applied only at the cycle boundary.
- Sits behind the AXI-lite register wrapper of the PWM IP and drives the pins directly.

---
 rtl/pwm_pkg.sv | 19 +
 rtl/pwm_cmp_ch.sv | 56 +++++
 rtl/pwm_mch.sv | 115 +++++++++++
 tb/tb_pwm_mch.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared definitions for the multi-channel PWM block.
//   MODE_EDGE / MODE_CENTER : encoding of the mode input and its shadow.
//   dir_e                   : timebase counting direction.
//   duty_lsb()              : LSB position of channel i inside the packed duty bus.
package pwm_pkg;

    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTER = 1'b1;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    function automatic int unsigned duty_lsb(input int unsigned ch, input int unsigned w);
        return ch * w;
    endfunction

endpackage

// File: rtl/pwm_cmp_ch.sv
// pwm_cmp_ch: one PWM output channel.
//   clk, srst_n : clock and synchronous active-low reset.
//   en          : global run enable (0 forces the inactive level).
//   ld          : transfer strobe, copies duty/ch_en/ch_inv into the shadows.
//   cnt         : shared timebase value.
//   duty        : working duty compare value.
//   ch_en       : working channel enable.
//   ch_inv      : working output invert.
//   pwm_out     : registered output, one clock behind cnt.
module pwm_cmp_ch #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         srst_n,
    input  logic         en,
    input  logic         ld,
    input  logic [W-1:0] cnt,
    input  logic [W-1:0] duty,
    input  logic         ch_en,
    input  logic         ch_inv,
    output logic         pwm_out
);

    logic [W-1:0] duty_q, duty_d;
    logic         ch_en_q, ch_en_d;
    logic         ch_inv_q, ch_inv_d;
    logic         pwm_q, pwm_d;
    logic         raw;

    always_comb begin
        duty_d   = ld ? duty   : duty_q;
        ch_en_d  = ld ? ch_en  : ch_en_q;
        ch_inv_d = ld ? ch_inv : ch_inv_q;
        // Output uses the shadows active in this cycle; a transfer on the
        // same edge only affects the following cycle, so no mid-cycle edge.
        raw      = ch_en_q & (cnt < duty_q);
        pwm_d    = en ? (raw ^ ch_inv_q) : ch_inv_q;
    end

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            duty_q   <= '0;
            ch_en_q  <= 1'b0;
            ch_inv_q <= 1'b0;
            pwm_q    <= 1'b0;
        end else begin
            duty_q   <= duty_d;
            ch_en_q  <= ch_en_d;
            ch_inv_q <= ch_inv_d;
            pwm_q    <= pwm_d;
        end
    end

    assign pwm_out = pwm_q;

endmodule

// File: rtl/pwm_mch.sv
// pwm_mch: N-channel PWM generator with a shared timebase, edge- or
// centre-aligned counting and shadowed settings applied at cycle boundaries.
//   clk, srst_n : clock and synchronous active-low reset.
//   en          : global run enable.
//   mode        : 0 edge-aligned, 1 centre-aligned.
//   period      : timebase top value.
//   duty        : per-channel compare values, channel i at [i*W +: W].
//   ch_en       : per-channel enable.
//   ch_inv      : per-channel invert.
//   load        : request to transfer the working set into the shadows.
//   load_ack    : pulse in the first cycle the new shadows are in effect.
//   cyc_start   : pulse in each cycle where the timebase is at 0 and running.
//   pwm_out     : registered channel outputs.
module pwm_mch
    import pwm_pkg::*;
#(
    parameter int W = 32,
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           srst_n,
    input  logic           en,
    input  logic           mode,
    input  logic [W-1:0]   period,
    input  logic [N*W-1:0] duty,
    input  logic [N-1:0]   ch_en,
    input  logic [N-1:0]   ch_inv,
    input  logic           load,
    output logic           load_ack,
    output logic           cyc_start,
    output logic [N-1:0]   pwm_out
);

    logic [W-1:0] cnt_q, cnt_d, cnt_nxt;
    dir_e         dir_q, dir_d, dir_nxt;
    logic [W-1:0] period_q, period_d;
    logic         mode_q, mode_d;
    logic         load_pend_q, load_pend_d;
    logic         load_ack_q, load_ack_d;
    logic         xfer;

    always_comb begin
        // Free-running successor of the timebase under the current shadows.
        cnt_nxt = '0;
        dir_nxt = DIR_UP;
        if (mode_q == MODE_EDGE) begin
            if (cnt_q < period_q) cnt_nxt = cnt_q + 1'b1;
        end else if (dir_q == DIR_UP) begin
            if (cnt_q < period_q) begin
                cnt_nxt = cnt_q + 1'b1;
            end else if (period_q > W'(1)) begin
                cnt_nxt = period_q - 1'b1;
                dir_nxt = DIR_DOWN;
            end
            // period 0/1: falls straight back to 0 going up
        end else begin
            cnt_nxt = cnt_q - 1'b1;
            if (cnt_q != W'(1)) dir_nxt = DIR_DOWN;
        end

        // cnt_nxt==0 always comes with dir_nxt==UP, so it marks the boundary
        // in both modes.
        xfer        = (load_pend_q | load) & (~en | (cnt_nxt == '0));
        period_d    = xfer ? period : period_q;
        mode_d      = xfer ? mode   : mode_q;
        load_pend_d = ~xfer & (load_pend_q | load);
        load_ack_d  = xfer;

        // A transfer always restarts from 0 going up (covers mode changes).
        if (en && !xfer) begin
            cnt_d = cnt_nxt;
            dir_d = dir_nxt;
        end else begin
            cnt_d = '0;
            dir_d = DIR_UP;
        end
    end

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            cnt_q       <= '0;
            dir_q       <= DIR_UP;
            period_q    <= '0;
            mode_q      <= MODE_EDGE;
            load_pend_q <= 1'b0;
            load_ack_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            period_q    <= period_d;
            mode_q      <= mode_d;
            load_pend_q <= load_pend_d;
            load_ack_q  <= load_ack_d;
        end
    end

    assign load_ack  = load_ack_q;
    // Gated by srst_n so the pulse stays low while reset is held.
    assign cyc_start = en & srst_n & (cnt_q == '0);

    for (genvar i = 0; i < N; i++) begin : g_ch
        pwm_cmp_ch #(.W(W)) u_ch (
            .clk     (clk),
            .srst_n  (srst_n),
            .en      (en),
            .ld      (xfer),
            .cnt     (cnt_q),
            .duty    (duty[duty_lsb(i, W) +: W]),
            .ch_en   (ch_en[i]),
            .ch_inv  (ch_inv[i]),
            .pwm_out (pwm_out[i])
        );
    end

endmodule

// File: tb/tb_pwm_mch.sv
module tb_pwm_mch;
    localparam int W = 8;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           srst_n, en, mode, load;
    logic [W-1:0]   period;
    logic [N*W-1:0] duty;
    logic [N-1:0]   ch_en, ch_inv;
    logic           load_ack, cyc_start;
    logic [N-1:0]   pwm_out;

    int checks = 0;
    int errors = 0;
    bit chk_on = 0;

    pwm_mch #(.W(W), .N(N)) dut (
        .clk(clk), .srst_n(srst_n), .en(en), .mode(mode), .period(period),
        .duty(duty), .ch_en(ch_en), .ch_inv(ch_inv), .load(load),
        .load_ack(load_ack), .cyc_start(cyc_start), .pwm_out(pwm_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks position k inside the PWM cycle; the counter value is derived
    // from k (triangle for centre mode) instead of an up/down register.
    int           m_k, m_P;
    logic         m_mode, m_pend, m_ack;
    int           m_D[N];
    logic [N-1:0] m_en, m_inv, m_pwm;

    initial forever begin
        @(posedge clk);
        if (!srst_n) begin
            m_k = 0; m_P = 0; m_mode = 0; m_pend = 0; m_ack = 0;
            m_en = '0; m_inv = '0; m_pwm = '0;
            for (int i = 0; i < N; i++) m_D[i] = 0;
        end else begin
            int c, len, nk;
            bit xf;
            c   = (m_mode == 1'b0 || m_k <= m_P) ? m_k : 2 * m_P - m_k;
            for (int i = 0; i < N; i++)
                m_pwm[i] = en ? ((m_en[i] && c < m_D[i]) ^ m_inv[i]) : m_inv[i];
            len = (m_mode == 1'b0) ? m_P + 1 : (m_P == 0 ? 1 : 2 * m_P);
            nk  = (m_k + 1) % len;
            xf  = (m_pend || load) && (!en || nk == 0);
            m_ack  = xf;
            m_pend = !xf && (m_pend || load);
            if (xf) begin
                m_P = int'(period); m_mode = mode; m_en = ch_en; m_inv = ch_inv;
                for (int i = 0; i < N; i++) m_D[i] = int'(duty[i*W +: W]);
            end
            m_k = (en && !xf) ? nk : 0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            chk("load_ack", 32'(load_ack), 32'(m_ack));
            chk("cyc_start", 32'(cyc_start), 32'(en && srst_n && m_k == 0));
            chk("pwm_out", 32'(pwm_out), 32'(m_pwm));
        end
    end

    // ---------------- stimulus helpers ----------------
    int w_hi[N];
    int w_cs, w_ack;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic window(input int n);
        w_cs = 0; w_ack = 0;
        for (int i = 0; i < N; i++) w_hi[i] = 0;
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            w_cs  += int'(cyc_start);
            w_ack += int'(load_ack);
            for (int i = 0; i < N; i++) w_hi[i] += int'(pwm_out[i]);
        end
        @(posedge clk); #1;
    endtask

    // Returns in the drive phase of the cycle with cnt==1.
    task automatic wait_cs();
        int t = 0;
        @(negedge clk);
        while (cyc_start !== 1'b1 && t < 60) begin @(negedge clk); t++; end
        checks++;
        if (t >= 60) begin
            errors++;
            $display("FAIL cyc_start_wait: got timeout expected pulse within 60 clks");
        end
        @(posedge clk); #1;
    endtask

    task automatic set_duty(input int d0, input int d1, input int d2, input int d3);
        duty[0*W +: W] = W'(d0); duty[1*W +: W] = W'(d1);
        duty[2*W +: W] = W'(d2); duty[3*W +: W] = W'(d3);
    endtask

    task automatic do_load();
        load = 1'b1; step(1); load = 1'b0;
    endtask

    initial begin
        int a, b, acks, ack6;
        srst_n = 0; en = 0; mode = 0; load = 0; period = '0; duty = '0;
        ch_en = '0; ch_inv = '0;
        @(posedge clk); #1;
        chk_on = 1;

        // 1: reset then idle
        step(2);
        @(negedge clk);
        chk("rst_pwm", 32'(pwm_out), 32'h0);
        chk("rst_ack", 32'(load_ack), 32'h0);
        chk("rst_cs", 32'(cyc_start), 32'h0);
        @(posedge clk); #1;
        srst_n = 1; step(1);
        @(negedge clk);
        chk("idle_pwm", 32'(pwm_out), 32'h0);
        chk("idle_ack", 32'(load_ack), 32'h0);
        @(posedge clk); #1;

        // 2: edge mode P=9, D={0,3,10,255}
        period = 8'd9; mode = 0; set_duty(0, 3, 10, 255); ch_en = 4'hF; en = 1;
        do_load();
        step(12);
        window(20);
        chk("edge_ch0_hi", 32'(w_hi[0]), 32'd0);
        chk("edge_ch1_hi", 32'(w_hi[1]), 32'd6);
        chk("edge_ch2_hi", 32'(w_hi[2]), 32'd20);
        chk("edge_ch3_hi", 32'(w_hi[3]), 32'd20);
        chk("edge_cs_cnt", 32'(w_cs), 32'd2);

        // 3: centre mode P=4, D1=2
        mode = 1; period = 8'd4; set_duty(0, 2, 0, 0);
        do_load();
        step(30);
        window(16);
        chk("ctr_ch1_hi", 32'(w_hi[1]), 32'd6);
        chk("ctr_ch0_hi", 32'(w_hi[0]), 32'd0);
        chk("ctr_cs_cnt", 32'(w_cs), 32'd2);

        // 4: shadow update mid-cycle, two loads, one ack
        mode = 0; period = 8'd9; set_duty(0, 3, 10, 255);
        do_load();
        step(25);
        wait_cs(); step(3);             // drive phase at cnt==4
        a = 0; b = 0; acks = 0; ack6 = 0;
        for (int j = 0; j < 16; j++) begin
            if (j == 0) duty[1*W +: W] = 8'd7;
            load = (j == 0 || j == 2);
            @(negedge clk);
            if (j < 6) a += int'(pwm_out[1]); else b += int'(pwm_out[1]);
            acks += int'(load_ack);
            if (j == 6) ack6 = int'(load_ack);
            @(posedge clk); #1;
        end
        load = 0;
        chk("upd_old_hi", 32'(a), 32'd0);
        chk("upd_new_hi", 32'(b), 32'd7);
        chk("upd_ack_cnt", 32'(acks), 32'd1);
        chk("upd_ack_at_wrap", 32'(ack6), 32'd1);

        // 5: invert and disable
        ch_inv = 4'b0101; set_duty(3, 3, 3, 3); ch_en = 4'hF;
        do_load();
        step(25);
        window(10);
        chk("inv_ch0_hi", 32'(w_hi[0]), 32'd7);
        chk("inv_ch1_hi", 32'(w_hi[1]), 32'd3);
        chk("inv_ch2_hi", 32'(w_hi[2]), 32'd7);
        chk("inv_ch3_hi", 32'(w_hi[3]), 32'd3);
        wait_cs(); step(4);             // cnt==5
        en = 0; step(1);
        @(negedge clk);
        chk("dis_pwm", 32'(pwm_out), 32'h5);
        chk("dis_cs", 32'(cyc_start), 32'h0);
        @(posedge clk); #1;
        en = 1;
        @(negedge clk);
        chk("reen_cs", 32'(cyc_start), 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("reen_pwm_cnt0", 32'(pwm_out), 32'ha);
        @(posedge clk); #1;

        // 6: reset mid-operation with a load pending
        wait_cs(); step(3);             // cnt==4
        period = 8'd5; load = 1; step(1); load = 0;
        step(1);                        // cnt==6
        srst_n = 0; step(1); srst_n = 1;
        @(negedge clk);
        chk("mrst_pwm", 32'(pwm_out), 32'h0);
        chk("mrst_ack", 32'(load_ack), 32'h0);
        @(posedge clk); #1;
        window(30);
        chk("mrst_ack_cnt", 32'(w_ack), 32'd0);
        chk("mrst_cs_cnt", 32'(w_cs), 32'd30);
        chk("mrst_ch1_hi", 32'(w_hi[1]), 32'd0);

        // randomized run against the model
        for (int n = 0; n < 3000; n++) begin
            srst_n = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 99) < 4) en = ~en;
            load = ($urandom_range(0, 99) < 8);
            if ($urandom_range(0, 99) < 15) begin
                period = W'($urandom_range(0, 12));
                mode   = 1'($urandom_range(0, 1));
                for (int i = 0; i < N; i++)
                    duty[i*W +: W] = ($urandom_range(0, 9) == 0) ? 8'd255 : W'($urandom_range(0, 15));
                ch_en  = N'($urandom);
                ch_inv = N'($urandom);
            end
            step(1);
        end

        chk_on = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
